irq_sink_notifier: RTL and testbench
====================================

Name: irq_sink_notifier

Overview:
- Receiving end of the interrupt line that `source` drives.
- Detects rising edges on the incoming interrupt and counts them.
- Reports each event upstream as an AXI4-Lite master write of the running event count to a fixed doorbell address.
- Sits between an interrupt-producing block and the host-side AXI interconnect. Bursts of interrupts that arrive while a write is in flight are coalesced into one write.

Parameters:
- NOTIFY_ADDR, 32'h0000_1000, byte address written on every notification.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = edges are counted and notified; 0 = edges are ignored
- irq_in  in  1  interrupt input, synchronous to clk
- event_count  out  32  edges accepted since reset; wraps 32'hFFFF_FFFF -> 0
- error_count  out  ERR_W  B responses with BRESP != OKAY; saturates at all-ones
- busy  out  1  1 whenever the FSM is not IDLE
- M_AXI_AWADDR  out  32  write address
- M_AXI_AWVALID  out  1
- M_AXI_AWPROT  out  3  tied 3'b000
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32  write data
- M_AXI_WVALID  out  1
- M_AXI_WSTRB  out  4  tied 4'hF
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- Read channels (AR/R) are not present; this block never reads.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset=1 sampled at posedge clk).
- Reset values:
  - event_count=0, error_count=0, pending=0, irq_prev=0.
  - AWVALID=0, WVALID=0, BREADY=0, busy=0, state=IDLE.
  - AWADDR and WDATA are don't-care while their VALID is low.
- Edge detect:
  - irq_prev <= irq_in every cycle.
  - edge = irq_in & ~irq_prev & enable.
  - A multi-cycle high level counts as exactly one edge.
- Event capture: on edge in cycle t, event_count increments at t+1 and pending is set at t+1.
- FSM states:
  - IDLE: if pending, go to SEND at the next posedge. On that posedge: AWVALID=1, WVALID=1, AWADDR=NOTIFY_ADDR, WDATA=event_count (registered value at that posedge), pending cleared.
  - SEND:
    - AWVALID drops the cycle after AWVALID&AWREADY; WVALID drops the cycle after WVALID&WREADY. The two handshakes are independent and may occur in either order or the same cycle.
    - AWADDR and WDATA stay stable while their VALID is high.
    - When both handshakes have completed, go to WAIT_B with BREADY=1.
  - WAIT_B:
    - On BVALID&BREADY: BREADY drops and the FSM returns to IDLE.
    - If BRESP != 2'b00, error_count increments (saturating).
- Latency: edge in cycle t -> AWVALID/WVALID high at t+2 if FSM was IDLE and pending was clear.
- Minimum cycles per notification is 4 (IDLE, SEND, WAIT_B, back to IDLE) with zero-wait slave.
- Coalescing:
  - Edges during SEND or WAIT_B increment event_count and set pending.
  - On return to IDLE, one further write carries the latest count.
  - No notification is ever lost; intermediate counts may be skipped.
- Simultaneous events: an edge in the same cycle that IDLE clears pending leaves pending=1 (set wins over clear). Its count is not in the WDATA being launched, so a follow-up write results.
- enable:
  - enable=0 masks new edges only.
  - An in-flight transaction completes normally.
  - An already-set pending still launches its write.
- Reset mid-transaction:
  - All VALID/READY outputs drop at the reset posedge and counters clear.
  - The interconnect must be reset together with this block.
- VALID never depends combinationally on READY.

Test Plan:
- Reset, enable=1, one-cycle pulse on irq_in at cycle 10, zero-wait slave -> AWVALID/WVALID high at cycle 12 with AWADDR=32'h1000, WDATA=1, WSTRB=F. One B beat follows; event_count=1, busy back to 0.
- Hold irq_in high for 50 cycles -> exactly one write with WDATA=1.
- Slave holds AWREADY low 5 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID holds 5 cycles with stable AWADDR, then WAIT_B.
- Three edges while slave delays BVALID 20 cycles after the first write -> exactly two writes: WDATA=1, then WDATA=4; event_count=4.
- BRESP=2'b10 on two writes, 2'b00 on one -> error_count=2.
- enable=0 with 4 edges -> no writes, event_count=0.
- Assert reset during SEND -> next cycle AWVALID=WVALID=BREADY=0, event_count=0, busy=0.

Source files
------------

// File: rtl/irq_sink_notifier_if.sv
// irq_sink_notifier_if
//   AXI4-Lite write-only channel bundle (AW, W, B) used by the interrupt
//   sink notifier. No read channels: the notifier never reads.
//
//   awaddr/awvalid/awprot/awready : write address channel
//   wdata/wvalid/wstrb/wready     : write data channel
//   bresp/bvalid/bready           : write response channel
//
//   master : the notifier (drives AW/W, accepts B)
//   slave  : the interconnect / doorbell target
interface irq_sink_notifier_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [2:0]  awprot;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic [3:0]  wstrb;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/irq_sink_notifier.sv
// irq_sink_notifier
//   Receives a synchronous interrupt line, counts its rising edges and
//   reports each event to the host by writing the running event count to a
//   fixed doorbell address over AXI4-Lite. Edges arriving while a write is
//   outstanding are coalesced into one follow-up write carrying the latest
//   count.
//
//   Ports:
//     clk          system clock
//     reset        synchronous, active-high reset
//     enable       1 = count and notify edges, 0 = ignore new edges
//     irq_in       interrupt input, synchronous to clk
//     event_count  edges accepted since reset (wraps)
//     error_count  B responses with BRESP != OKAY (saturating)
//     busy         FSM is not IDLE
//     m_axi        AXI4-Lite write master (AW, W, B)
//
//   State table:
//     IDLE   | no write outstanding; launches one when pending is set
//     SEND   | AWVALID/WVALID presented; waiting for both handshakes
//     WAIT_B | both beats accepted; BREADY high until the B beat arrives
module irq_sink_notifier #(
  parameter logic [31:0] NOTIFY_ADDR = 32'h0000_1000,
  parameter int          ERR_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                irq_in,
  output logic [31:0]         event_count,
  output logic [ERR_W-1:0]    error_count,
  output logic                busy,
  irq_sink_notifier_if.master m_axi
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_next;

  logic        irq_prev;
  logic        irq_edge;
  logic        pending;
  logic        pending_clr;
  logic        b_err;

  logic        awvalid_q;
  logic        awvalid_next;
  logic        wvalid_q;
  logic        wvalid_next;
  logic        bready_q;
  logic        bready_next;
  logic [31:0] awaddr_q;
  logic [31:0] awaddr_next;
  logic [31:0] wdata_q;
  logic [31:0] wdata_next;

  assign irq_edge = irq_in & ~irq_prev & enable;

  assign busy          = (state != IDLE);
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.bready  = bready_q;

  // Next-state and next-output logic. All channel outputs are registered,
  // so no VALID ever follows a READY combinationally.
  always_comb begin
    state_next   = state;
    awvalid_next = awvalid_q;
    wvalid_next  = wvalid_q;
    bready_next  = bready_q;
    awaddr_next  = awaddr_q;
    wdata_next   = wdata_q;
    pending_clr  = 1'b0;
    b_err        = 1'b0;

    case (state)
      IDLE: begin
        if (pending) begin
          state_next   = SEND;
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          awaddr_next  = NOTIFY_ADDR;
          // Count as registered now; an edge in this same cycle lands after
          // this snapshot and re-arms pending for a follow-up write.
          wdata_next   = event_count;
          pending_clr  = 1'b1;
        end
      end

      SEND: begin
        if (awvalid_q && m_axi.awready) begin
          awvalid_next = 1'b0;
        end
        if (wvalid_q && m_axi.wready) begin
          wvalid_next = 1'b0;
        end
        // AW and W complete independently; move on once neither is pending.
        if (!awvalid_next && !wvalid_next) begin
          state_next  = WAIT_B;
          bready_next = 1'b1;
        end
      end

      WAIT_B: begin
        if (m_axi.bvalid) begin
          bready_next = 1'b0;
          state_next  = IDLE;
          b_err       = (m_axi.bresp != 2'b00);
        end
      end

      default: begin
        state_next   = IDLE;
        awvalid_next = 1'b0;
        wvalid_next  = 1'b0;
        bready_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_next;
      awvalid_q <= awvalid_next;
      wvalid_q  <= wvalid_next;
      bready_q  <= bready_next;
      awaddr_q  <= awaddr_next;
      wdata_q   <= wdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev    <= 1'b0;
      event_count <= '0;
      pending     <= 1'b0;
      error_count <= '0;
    end else begin
      irq_prev <= irq_in;

      if (irq_edge) begin
        event_count <= event_count + 32'd1;
      end

      // A new edge wins over the clear issued when a write is launched.
      if (irq_edge) begin
        pending <= 1'b1;
      end else if (pending_clr) begin
        pending <= 1'b0;
      end

      if (b_err && (error_count != ERR_MAX)) begin
        error_count <= error_count + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_irq_sink_notifier.sv
module tb_irq_sink_notifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        irq_in;
  logic [31:0] event_count;
  logic [15:0] error_count;
  logic        busy;

  irq_sink_notifier_if m_axi ();

  irq_sink_notifier #(
    .NOTIFY_ADDR (32'h0000_1000),
    .ERR_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .irq_in      (irq_in),
    .event_count (event_count),
    .error_count (error_count),
    .busy        (busy),
    .m_axi       (m_axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // slave model knobs and observations
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          b_delay  = 0;
  logic [1:0]  resp_val = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          n_writes = 0, n_aw = 0, n_b = 0;
  int          aw_wait = 0, w_high = 0, addr_bad = 0;
  logic [31:0] last_awaddr = '0;
  logic [31:0] wlog [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // AXI4-Lite slave: observe handshakes on the negedge before the posedge
  // that completes them, then update READY/BVALID just after the posedge.
  initial begin
    m_axi.awready = 1'b0;
    m_axi.wready  = 1'b0;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m_axi.awvalid === 1'b1) begin
          if (m_axi.awaddr !== 32'h0000_1000) addr_bad++;
          if (m_axi.awready) begin
            n_aw++;
            last_awaddr = m_axi.awaddr;
            aw_cnt = 0;
          end else begin
            aw_wait++;
            aw_cnt++;
          end
        end
        if (m_axi.wvalid === 1'b1) begin
          w_high++;
          if (m_axi.wready) begin
            if (n_writes < 16) wlog[n_writes] = m_axi.wdata;
            n_writes++;
            w_cnt = 0;
          end else begin
            w_cnt++;
          end
        end
        if (m_axi.bready === 1'b1) begin
          if (m_axi.bvalid) begin
            n_b++;
            b_cnt = 0;
          end else begin
            b_cnt++;
          end
        end
      end
      @(posedge clk);
      #1;
      m_axi.awready = (m_axi.awvalid === 1'b1) && (aw_cnt >= aw_delay);
      m_axi.wready  = (m_axi.wvalid === 1'b1) && (w_cnt >= w_delay);
      m_axi.bvalid  = (m_axi.bready === 1'b1) && (b_cnt >= b_delay) && !reset;
      m_axi.bresp   = m_axi.bvalid ? resp_val : 2'b00;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset  = 1'b1;
    irq_in = 1'b0;
    cyc();
    cyc();
    n_writes = 0; n_aw = 0; n_b = 0;
    aw_wait = 0; w_high = 0; addr_bad = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    for (int i = 0; i < 16; i++) wlog[i] = '0;
    reset = 1'b0;
  endtask

  task automatic pulse();
    irq_in = 1'b1;
    cyc();
    irq_in = 1'b0;
    cyc();
  endtask

  task automatic wait_idle();
    int streak;
    streak = 0;
    for (int i = 0; i < 400 && streak < 6; i++) begin
      cyc();
      if (busy === 1'b0) streak++;
      else streak = 0;
    end
    chk("idle_reached", 32'(streak >= 6), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    enable = 1'b1;
    irq_in = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    reset_dut();

    // reset state
    chk("rst_event_count", event_count, 32'd0);
    chk("rst_error_count", 32'(error_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_awvalid", 32'(m_axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_axi.wvalid), 32'd0);
    chk("rst_bready", 32'(m_axi.bready), 32'd0);

    // single pulse, zero-wait slave: VALIDs two cycles after the edge
    repeat (8) cyc();
    irq_in = 1'b1;
    cyc();
    irq_in = 1'b0;
    chk("p1_count_t1", event_count, 32'd1);
    chk("p1_awvalid_t1", 32'(m_axi.awvalid), 32'd0);
    chk("p1_busy_t1", 32'(busy), 32'd0);
    cyc();
    chk("p1_awvalid_t2", 32'(m_axi.awvalid), 32'd1);
    chk("p1_wvalid_t2", 32'(m_axi.wvalid), 32'd1);
    chk("p1_awaddr", m_axi.awaddr, 32'h0000_1000);
    chk("p1_wdata", m_axi.wdata, 32'd1);
    chk("p1_wstrb", 32'(m_axi.wstrb), 32'hF);
    chk("p1_awprot", 32'(m_axi.awprot), 32'd0);
    wait_idle();
    chk("p1_writes", n_writes, 32'd1);
    chk("p1_b_beats", n_b, 32'd1);
    chk("p1_last_awaddr", last_awaddr, 32'h0000_1000);
    chk("p1_event_count", event_count, 32'd1);
    chk("p1_busy_end", 32'(busy), 32'd0);

    // held-high level counts once
    reset_dut();
    irq_in = 1'b1;
    repeat (50) cyc();
    irq_in = 1'b0;
    wait_idle();
    chk("lvl_writes", n_writes, 32'd1);
    chk("lvl_wdata", wlog[0], 32'd1);
    chk("lvl_event_count", event_count, 32'd1);

    // AWREADY held off 5 cycles, WREADY immediate
    reset_dut();
    aw_delay = 5;
    pulse();
    wait_idle();
    chk("awd_aw_wait", aw_wait, 32'd5);
    chk("awd_w_high", w_high, 32'd1);
    chk("awd_addr_stable", addr_bad, 32'd0);
    chk("awd_aw_beats", n_aw, 32'd1);
    chk("awd_b_beats", n_b, 32'd1);
    aw_delay = 0;

    // coalescing: three edges while B is held off
    reset_dut();
    b_delay = 20;
    pulse();
    pulse();
    pulse();
    pulse();
    wait_idle();
    chk("coal_writes", n_writes, 32'd2);
    chk("coal_wdata0", wlog[0], 32'd1);
    chk("coal_wdata1", wlog[1], 32'd4);
    chk("coal_event_count", event_count, 32'd4);
    b_delay = 0;

    // error responses
    reset_dut();
    resp_val = 2'b10;
    pulse();
    wait_idle();
    resp_val = 2'b00;
    pulse();
    wait_idle();
    resp_val = 2'b10;
    pulse();
    wait_idle();
    resp_val = 2'b00;
    chk("err_writes", n_writes, 32'd3);
    chk("err_error_count", 32'(error_count), 32'd2);
    chk("err_event_count", event_count, 32'd3);

    // enable low masks edges
    reset_dut();
    enable = 1'b0;
    repeat (4) pulse();
    wait_idle();
    chk("dis_writes", n_writes, 32'd0);
    chk("dis_event_count", event_count, 32'd0);
    enable = 1'b1;

    // reset while in SEND
    reset_dut();
    aw_delay = 5;
    pulse();
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_awvalid_before", 32'(m_axi.awvalid), 32'd1);
    reset = 1'b1;
    cyc();
    chk("mid_awvalid", 32'(m_axi.awvalid), 32'd0);
    chk("mid_wvalid", 32'(m_axi.wvalid), 32'd0);
    chk("mid_bready", 32'(m_axi.bready), 32'd0);
    chk("mid_event_count", event_count, 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    aw_delay = 0;
    reset_dut();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
